fdiv_sqrt_sequencer: RTL and testbench

- Sequences the shared iterative floating-point divide/square-root unit for the FP issue path.
- Accepts one FDiv-class uop at a time, decodes it into unit command signals, launches the unit and waits for completion.
- Holds the result until writeback accepts it.
- Handles pipeline flush and tag-targeted kill, including draining an operation already in flight, and watches for a hung unit.

---
 rtl/fdiv_sqrt_sequencer_if.sv | 59 +++++
 rtl/fdiv_sqrt_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fdiv_sqrt_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdiv_sqrt_sequencer_if.sv
// Bundle of request, div/sqrt unit command, response and kill signals around
// the FDiv/FSqrt sequencer. The "slave" modport is the sequencer side.
interface fdiv_sqrt_sequencer_if #(
    parameter int DATA_W = 65,
    parameter int TAG_W  = 7
);
    logic              req_valid;
    logic              req_ready;
    logic [6:0]        req_uopc;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [2:0]        req_rm;

    logic              unit_start;
    logic              unit_ready;
    logic              unit_div;
    logic              unit_sqrt;
    logic [1:0]        unit_type_tag;
    logic [DATA_W-1:0] unit_a;
    logic [DATA_W-1:0] unit_b;
    logic [2:0]        unit_rm;
    logic              unit_done;
    logic [DATA_W-1:0] unit_result;
    logic [4:0]        unit_exc;

    logic              resp_valid;
    logic              resp_ready;
    logic [TAG_W-1:0]  resp_tag;
    logic [DATA_W-1:0] resp_data;
    logic [4:0]        resp_exc;

    logic              flush;
    logic              kill_valid;
    logic [TAG_W-1:0]  kill_tag;

    // Handshakes: a transfer occurs on a rising edge where valid (or start) and
    // ready are both high; payload is held stable while valid is high and not
    // yet accepted. unit_done is a single-cycle pulse with no back-pressure.
    modport slave (
        input  req_valid, req_uopc, req_tag, req_a, req_b, req_rm,
        output req_ready,
        output unit_start, unit_div, unit_sqrt, unit_type_tag, unit_a, unit_b, unit_rm,
        input  unit_ready, unit_done, unit_result, unit_exc,
        output resp_valid, resp_tag, resp_data, resp_exc,
        input  resp_ready,
        input  flush, kill_valid, kill_tag
    );

    modport master (
        output req_valid, req_uopc, req_tag, req_a, req_b, req_rm,
        input  req_ready,
        input  unit_start, unit_div, unit_sqrt, unit_type_tag, unit_a, unit_b, unit_rm,
        output unit_ready, unit_done, unit_result, unit_exc,
        input  resp_valid, resp_tag, resp_data, resp_exc,
        output resp_ready,
        output flush, kill_valid, kill_tag
    );
endinterface

// File: rtl/fdiv_sqrt_sequencer.sv
// Single-uop sequencer for the shared iterative FP divide/sqrt unit: decode,
// launch, wait, hold result for writeback, with flush/kill drain and a hang timer.
module fdiv_sqrt_sequencer #(
    parameter int DATA_W  = 65,
    parameter int TAG_W   = 7,
    parameter int TIMEOUT = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    fdiv_sqrt_sequencer_if.slave io,
    output logic                 busy,
    output logic                 err,
    output logic [2:0]           state_dbg
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [2:0]        state_q, state_d;
    logic              div_q, div_d;
    logic              sqrt_q, sqrt_d;
    logic [1:0]        type_tag_q, type_tag_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        rm_q, rm_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [4:0]        exc_q, exc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              kill;
    logic              accept;
    logic              unused_uopc;

    // The tag compare is meaningless in IDLE since no uop is held there.
    assign kill   = io.flush |
                    (io.kill_valid & (state_q != S_IDLE) & (io.kill_tag == tag_q));
    assign accept = io.req_valid & io.req_ready;

    assign unused_uopc = ^io.req_uopc[6:4];

    assign io.req_ready     = (state_q == S_IDLE) & ~io.flush;
    assign io.unit_start    = (state_q == S_LAUNCH) & ~kill;
    assign io.resp_valid    = (state_q == S_RESP) & ~kill;

    assign io.unit_div      = div_q;
    assign io.unit_sqrt     = sqrt_q;
    assign io.unit_type_tag = type_tag_q;
    assign io.unit_a        = a_q;
    assign io.unit_b        = b_q;
    assign io.unit_rm       = rm_q;
    assign io.resp_tag      = tag_q;
    assign io.resp_data     = res_q;
    assign io.resp_exc      = exc_q;

    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sqrt_d     = sqrt_q;
        type_tag_d = type_tag_q;
        tag_d      = tag_q;
        a_d        = a_q;
        b_d        = b_q;
        rm_d       = rm_q;
        res_d      = res_q;
        exc_d      = exc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    type_tag_d = {1'b0, ~io.req_uopc[0]};
                    div_d      = (~io.req_uopc[3] & ~io.req_uopc[1]) |
                                 (~io.req_uopc[3] & ~io.req_uopc[0]);
                    sqrt_d     = ~io.req_uopc[2] | (io.req_uopc[1] & io.req_uopc[0]);
                    tag_d      = io.req_tag;
                    a_d        = io.req_a;
                    b_d        = io.req_b;
                    rm_d       = io.req_rm;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (io.unit_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (cnt_d == CNT_MAX) begin
                    err_d = 1'b1;
                end
                // A result arriving together with a kill belongs to a dead uop.
                if (io.unit_done && kill) begin
                    state_d = S_IDLE;
                end else if (io.unit_done) begin
                    res_d   = io.unit_result;
                    exc_d   = io.unit_exc;
                    state_d = S_RESP;
                end else if (kill) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (io.unit_done) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (kill || io.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A done pulse is only legal while the unit owns an operation.
        if (io.unit_done &&
            (state_q == S_IDLE || state_q == S_LAUNCH || state_q == S_RESP)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            div_q      <= 1'b0;
            sqrt_q     <= 1'b0;
            type_tag_q <= '0;
            tag_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rm_q       <= '0;
            res_q      <= '0;
            exc_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sqrt_q     <= sqrt_d;
            type_tag_q <= type_tag_d;
            tag_q      <= tag_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rm_q       <= rm_d;
            res_q      <= res_d;
            exc_q      <= exc_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_fdiv_sqrt_sequencer.sv
// Directed, table-driven bench for fdiv_sqrt_sequencer plus hand-written
// sequences for backpressure, flush/kill drain, timeout and async reset.
module tb_fdiv_sqrt_sequencer;
    localparam int DATA_W = 65;
    localparam int TAG_W  = 7;
    localparam int W      = TAG_W + DATA_W + 5;
    localparam int NV     = 7;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    typedef struct {
        logic [6:0]        uopc;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        rm;
        int                launch_stall;
        int                lat;
        int                resp_stall;
        logic [DATA_W-1:0] result;
        logic [4:0]        exc;
        logic              exp_div;
        logic              exp_sqrt;
        logic [1:0]        exp_tt;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       busy, err, t_busy, t_err;
    logic [2:0] st, t_st;

    int n_vec  = 0;
    int n_fail = 0;
    int launches = 0;
    int resp_cycles = 0;

    logic [W-1:0] exp_q[$];
    vec_t         vecs[NV];

    fdiv_sqrt_sequencer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) m_if ();
    fdiv_sqrt_sequencer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) t_if ();

    fdiv_sqrt_sequencer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT(256)) dut (
        .clock(clock), .reset(reset), .io(m_if.slave),
        .busy(busy), .err(err), .state_dbg(st)
    );

    fdiv_sqrt_sequencer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT(8)) dut_to (
        .clock(clock), .reset(reset), .io(t_if.slave),
        .busy(t_busy), .err(t_err), .state_dbg(t_st)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (m_if.unit_start && m_if.unit_ready) launches <= launches + 1;
        if (m_if.resp_valid) resp_cycles <= resp_cycles + 1;
    end

    // ---------------- driver / check tasks ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [6:0] uopc, input logic [TAG_W-1:0] tag);
        m_if.req_valid = 1'b1;
        m_if.req_uopc  = uopc;
        m_if.req_tag   = tag;
        m_if.req_a     = 65'h0_0000_0000_0000_00a1;
        m_if.req_b     = 65'h0_0000_0000_0000_00b2;
        m_if.req_rm    = 3'd1;
        cyc();
        m_if.req_valid = 1'b0;
    endtask

    task automatic go_to_wait(input logic [TAG_W-1:0] tag);
        accept(7'h00, tag);
        m_if.unit_ready = 1'b1;
        cyc();
        m_if.unit_ready = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        logic [W-1:0] e;
        int           l0;
        m_if.req_valid = 1'b1;
        m_if.req_uopc  = v.uopc;
        m_if.req_tag   = v.tag;
        m_if.req_a     = v.a;
        m_if.req_b     = v.b;
        m_if.req_rm    = v.rm;
        #1 chk("accept_ready", 80'(m_if.req_ready), 80'(1));
        cyc();
        m_if.req_valid = 1'b0;
        exp_q.push_back({v.tag, v.result, v.exc});
        l0 = launches;
        m_if.unit_ready = 1'b0;
        for (int i = 0; i < v.launch_stall; i++) begin
            #1 chk("start_held", 80'({m_if.unit_start, m_if.req_ready}), 80'(2'b10));
            cyc();
        end
        m_if.unit_ready = 1'b1;
        #1 chk("start", 80'(m_if.unit_start), 80'(1));
        chk("decode", 80'({m_if.unit_div, m_if.unit_sqrt, m_if.unit_type_tag}),
            80'({v.exp_div, v.exp_sqrt, v.exp_tt}));
        chk("held_a", 80'(m_if.unit_a), 80'(v.a));
        chk("held_b_rm", 80'({m_if.unit_b, m_if.unit_rm}), 80'({v.b, v.rm}));
        cyc();
        m_if.unit_ready = 1'b0;
        chk("one_launch", 80'(launches - l0), 80'(1));
        for (int i = 1; i < v.lat; i++) cyc();
        m_if.unit_done   = 1'b1;
        m_if.unit_result = v.result;
        m_if.unit_exc    = v.exc;
        cyc();
        m_if.unit_done   = 1'b0;
        m_if.unit_result = '0;
        m_if.unit_exc    = '0;
        e = exp_q.pop_front();
        for (int i = 0; i < v.resp_stall; i++) begin
            #1 chk("resp_hold", 80'({m_if.resp_valid, m_if.resp_tag, m_if.resp_data, m_if.resp_exc}),
                   80'({1'b1, e}));
            chk("ready_low_hold", 80'(m_if.req_ready), 80'(0));
            cyc();
        end
        m_if.resp_ready = 1'b1;
        #1 chk("resp", 80'({m_if.resp_valid, m_if.resp_tag, m_if.resp_data, m_if.resp_exc}),
               80'({1'b1, e}));
        chk("ready_low_resp", 80'(m_if.req_ready), 80'(0));
        cyc();
        m_if.resp_ready = 1'b0;
        #1 chk("back_idle", 80'({busy, m_if.req_ready, st}), 80'({1'b0, 1'b1, S_IDLE}));
    endtask

    // ---------------- test ----------------
    initial begin : main
        vec_t bp;
        int   r0;
        vecs[0] = '{7'h00, 7'd5,  65'h1_0000_0000_0000_0001, 65'h0_4000_0000_0000_0000, 3'd0,
                    0, 10, 0, 65'h1234, 5'h01, 1'b1, 1'b1, 2'b01};
        vecs[1] = '{7'h01, 7'd12, 65'h0_dead_beef_0000_0001, 65'h0_0000_0000_cafe_f00d, 3'd2,
                    0, 1, 0, 65'h1_ffff_0000_ffff_0000, 5'h10, 1'b1, 1'b1, 2'b00};
        vecs[2] = '{7'h03, 7'd33, 65'h0_1111_2222_3333_4444, 65'h0, 3'd3,
                    1, 3, 1, 65'h0_5555_aaaa_5555_aaaa, 5'h04, 1'b0, 1'b1, 2'b00};
        vecs[3] = '{7'h06, 7'd64, 65'h1_8000_0000_0000_0000, 65'h0_0000_0000_0000_0007, 3'd4,
                    2, 2, 0, 65'h0_0000_0000_0000_0abc, 5'h02, 1'b1, 1'b0, 2'b01};
        vecs[4] = '{7'h07, 7'd127, 65'h0_0f0f_0f0f_0f0f_0f0f, 65'h1_f0f0_f0f0_f0f0_f0f0, 3'd1,
                    0, 5, 2, 65'h1_0000_0000_0000_0000, 5'h1f, 1'b0, 1'b1, 2'b00};
        vecs[5] = '{7'h0c, 7'd0,  65'h0_0000_0000_0000_0002, 65'h0_0000_0000_0000_0003, 3'd0,
                    1, 4, 1, 65'h0_0000_0000_0000_0001, 5'h08, 1'b0, 1'b0, 2'b01};
        vecs[6] = '{7'h05, 7'd77, 65'h0_1234_5678_9abc_def0, 65'h0_0fed_cba9_8765_4321, 3'd7,
                    0, 2, 0, 65'h0_7777_7777_7777_7777, 5'h00, 1'b1, 1'b0, 2'b00};

        m_if.req_valid = 0; m_if.req_uopc = '0; m_if.req_tag = '0; m_if.req_a = '0;
        m_if.req_b = '0; m_if.req_rm = '0; m_if.unit_ready = 0; m_if.unit_done = 0;
        m_if.unit_result = '0; m_if.unit_exc = '0; m_if.resp_ready = 0; m_if.flush = 0;
        m_if.kill_valid = 0; m_if.kill_tag = '0;
        t_if.req_valid = 0; t_if.req_uopc = '0; t_if.req_tag = '0; t_if.req_a = '0;
        t_if.req_b = '0; t_if.req_rm = '0; t_if.unit_ready = 0; t_if.unit_done = 0;
        t_if.unit_result = '0; t_if.unit_exc = '0; t_if.resp_ready = 0; t_if.flush = 0;
        t_if.kill_valid = 0; t_if.kill_tag = '0;

        // reset state
        repeat (3) @(posedge clock);
        #1 chk("rst_outputs", 80'({busy, err, m_if.resp_valid, m_if.unit_start, m_if.unit_div}), 80'(0));
        chk("rst_regs", 80'({m_if.resp_data, m_if.resp_tag}), 80'(0));
        reset = 1'b1;
        #1 chk("rst_ready", 80'({m_if.req_ready, st}), 80'({1'b1, S_IDLE}));
        cyc();

        // table: basic divide first, then decode/latency variety
        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i]);
            repeat ($urandom_range(0, 2)) cyc();
        end

        // backpressure on both unit launch and writeback
        bp = vecs[1];
        bp.launch_stall = 4;
        bp.resp_stall   = 5;
        do_op(bp);

        // flush in WAIT cycle 3, done in cycle 8; kills during DRAIN are ignored
        r0 = resp_cycles;
        go_to_wait(7'd5);
        cyc(); cyc();
        m_if.flush = 1'b1;
        #1 chk("flush_no_ready", 80'(m_if.req_ready), 80'(0));
        cyc();
        m_if.flush = 1'b0;
        #1 chk("flush_drain", 80'(st), 80'(S_DRAIN));
        m_if.kill_valid = 1'b1;
        m_if.kill_tag   = 7'd5;
        repeat (4) cyc();
        m_if.kill_valid = 1'b0;
        #1 chk("drain_hold", 80'(st), 80'(S_DRAIN));
        m_if.unit_done   = 1'b1;
        m_if.unit_result = 65'h9999;
        cyc();
        m_if.unit_done = 1'b0;
        #1 chk("drain_idle", 80'({st, err}), 80'({S_IDLE, 1'b0}));
        chk("flush_no_resp", 80'(resp_cycles - r0), 80'(0));
        do_op(vecs[2]);

        // targeted kill in LAUNCH beats the launch handshake
        r0 = launches;
        accept(7'h00, 7'd5);
        m_if.unit_ready = 1'b1;
        m_if.kill_valid = 1'b1;
        m_if.kill_tag   = 7'd5;
        #1 chk("kill_launch_start", 80'(m_if.unit_start), 80'(0));
        cyc();
        m_if.kill_valid = 1'b0;
        m_if.unit_ready = 1'b0;
        #1 chk("kill_launch_idle", 80'({st, 32'(launches - r0)}), 80'({S_IDLE, 32'd0}));

        // non-matching kill tag has no effect; matching kill in RESP drops result
        accept(7'h00, 7'd5);
        m_if.unit_ready = 1'b1;
        m_if.kill_valid = 1'b1;
        m_if.kill_tag   = 7'd6;
        #1 chk("kill_other_start", 80'(m_if.unit_start), 80'(1));
        cyc();
        m_if.unit_ready = 1'b0;
        #1 chk("kill_other_wait", 80'(st), 80'(S_WAIT));
        m_if.kill_valid = 1'b0;
        m_if.unit_done  = 1'b1;
        cyc();
        m_if.unit_done  = 1'b0;
        m_if.kill_valid = 1'b1;
        m_if.kill_tag   = 7'd5;
        #1 chk("kill_resp_valid", 80'({st, m_if.resp_valid}), 80'({S_RESP, 1'b0}));
        cyc();
        m_if.kill_valid = 1'b0;
        #1 chk("kill_resp_idle", 80'(st), 80'(S_IDLE));

        // kill together with done in WAIT
        r0 = resp_cycles;
        go_to_wait(7'd9);
        m_if.kill_valid = 1'b1;
        m_if.kill_tag   = 7'd9;
        m_if.unit_done  = 1'b1;
        cyc();
        m_if.kill_valid = 1'b0;
        m_if.unit_done  = 1'b0;
        #1 chk("kill_done_idle", 80'({st, err}), 80'({S_IDLE, 1'b0}));
        repeat (2) cyc();
        chk("kill_done_no_resp", 80'(resp_cycles - r0), 80'(0));

        // timeout on the TIMEOUT=8 instance: err rises once 8 WAIT cycles elapse
        t_if.req_valid = 1'b1;
        t_if.req_tag   = 7'd3;
        cyc();
        t_if.req_valid  = 1'b0;
        t_if.unit_ready = 1'b1;
        #1 chk("to_launch", 80'(t_st), 80'(S_LAUNCH));
        cyc();
        t_if.unit_ready = 1'b0;
        for (int k = 1; k < 8; k++) cyc();
        #1 chk("to_err_before", 80'({t_err, t_st}), 80'({1'b0, S_WAIT}));
        cyc();
        #1 chk("to_err", 80'({t_err, t_st}), 80'({1'b1, S_WAIT}));
        repeat (3) cyc();
        chk("to_still_wait", 80'({t_err, t_st}), 80'({1'b1, S_WAIT}));
        t_if.flush = 1'b1;
        cyc();
        t_if.flush     = 1'b0;
        t_if.unit_done = 1'b1;
        cyc();
        t_if.unit_done = 1'b0;
        #1 chk("to_recover", 80'(t_st), 80'(S_IDLE));

        // spurious done in IDLE
        r0 = resp_cycles;
        chk("spur_pre", 80'(err), 80'(0));
        m_if.unit_done = 1'b1;
        cyc();
        m_if.unit_done = 1'b0;
        #1 chk("spur_err", 80'({err, st, m_if.resp_valid}), 80'({1'b1, S_IDLE, 1'b0}));
        chk("spur_no_resp", 80'(resp_cycles - r0), 80'(0));

        // async reset while in RESP
        go_to_wait(7'd21);
        m_if.unit_done   = 1'b1;
        m_if.unit_result = 65'h4242;
        cyc();
        m_if.unit_done = 1'b0;
        #1 chk("pre_reset_resp", 80'({m_if.resp_valid, m_if.resp_data}), 80'({1'b1, 65'h4242}));
        #1 reset = 1'b0;
        #1 chk("areset", 80'({m_if.resp_valid, busy, err, m_if.resp_data}), 80'(0));
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_reset", 80'({st, m_if.req_ready}), 80'({S_IDLE, 1'b1}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
